bp_table_scheduler: RTL and testbench

- Sequences all access to the single-ported, synchronous-read PHT/BTB table array of the gshare branch predictor.
- Arbitrates fetch-side lookups against resolve-side updates. Updates are buffered in a small FIFO so that lookups are rarely stalled.
- Owns the table-clear sweep after reset or flush, replacing per-entry reset loops in the table itself.

---
 rtl/bp_table_scheduler_if.sv | 35 +++
 rtl/bp_table_scheduler.sv | 140 ++++++++++++++
 tb/tb_bp_table_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_table_scheduler_if.sv
// bp_table_scheduler_if: lookup, update and table-port bundle of the branch-predictor table scheduler
interface bp_table_scheduler_if #(
    parameter int IDX_W    = 7,
    parameter int DATA_W   = 59,
    parameter int UQ_DEPTH = 4
);
    localparam int CW = $clog2(UQ_DEPTH) + 1;
    logic              flush;
    logic              lk_valid;
    logic [IDX_W-1:0]  lk_idx;
    logic              lk_ready;
    logic              lk_rvalid;
    logic [DATA_W-1:0] lk_rdata;
    logic              up_valid;
    logic [IDX_W-1:0]  up_idx;
    logic [DATA_W-1:0] up_wdata;
    logic              up_ready;
    logic              tbl_en;
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_idx;
    logic [DATA_W-1:0] tbl_wdata;
    logic [DATA_W-1:0] tbl_rdata;
    logic              busy_init;
    logic [CW-1:0]     uq_count;
    modport master (
        output flush, lk_valid, lk_idx, up_valid, up_idx, up_wdata, tbl_rdata,
        input  lk_ready, lk_rvalid, lk_rdata, up_ready, tbl_en, tbl_we, tbl_idx, tbl_wdata,
               busy_init, uq_count
    );
    modport slave (
        input  flush, lk_valid, lk_idx, up_valid, up_idx, up_wdata, tbl_rdata,
        output lk_ready, lk_rvalid, lk_rdata, up_ready, tbl_en, tbl_we, tbl_idx, tbl_wdata,
               busy_init, uq_count
    );
endinterface

// File: rtl/bp_table_scheduler.sv
// bp_table_scheduler: arbitrates PHT/BTB lookups vs queued updates and runs the clear sweep.
// Optional BP_SCHED_BYPASS_EN forwards queued update data to matching lookups.
module bp_table_scheduler #(
    parameter int IDX_W      = 7,
    parameter int DATA_W     = 59,
    parameter int UQ_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input logic                clk,
    input logic                rst,
    bp_table_scheduler_if.slave io_bus
);
    localparam int PW = $clog2(UQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_sweep;
    logic [IDX_W-1:0]  r_q_idx  [UQ_DEPTH];
    logic [DATA_W-1:0] r_q_data [UQ_DEPTH];
    logic [PW-1:0]     r_rp;
    logic [PW-1:0]     r_wp;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_starve;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_hold;
    logic              w_init;
    logic              w_run;
    logic              w_full;
    logic              w_ne;
    logic              w_wr;
    logic              w_grant;
    logic              w_push;
    logic [DATA_W-1:0] w_rd;

    assign w_init  = r_state == S_INIT;
    assign w_run   = r_state == S_RUN;
    assign w_full  = r_cnt == CW'(UQ_DEPTH);
    assign w_ne    = r_cnt != '0;
    // A full queue or a starved update outranks a pending lookup
    assign w_wr    = w_run && w_ne && (w_full || r_starve == SW'(STARVE_MAX) || !io_bus.lk_valid);
    assign w_grant = w_run && io_bus.lk_valid && !w_wr;
    assign w_push  = w_run && !w_full && io_bus.up_valid && !io_bus.flush;

    assign io_bus.lk_ready  = w_grant;
    assign io_bus.up_ready  = w_run && !w_full;
    assign io_bus.busy_init = w_init;
    assign io_bus.uq_count  = r_cnt;
    assign io_bus.lk_rvalid = r_rvalid;
    assign io_bus.tbl_en    = !rst && (w_init || w_wr || w_grant);
    assign io_bus.tbl_we    = !rst && (w_init || w_wr);
    assign io_bus.tbl_idx   = rst ? '0 : w_init ? r_sweep : w_wr ? r_q_idx[r_rp] :
                              w_grant ? io_bus.lk_idx : '0;
    assign io_bus.tbl_wdata = (!rst && w_wr) ? r_q_data[r_rp] : '0;
    assign io_bus.lk_rdata  = r_rvalid ? w_rd : r_hold;

`ifdef BP_SCHED_BYPASS_EN
    logic              w_hit;
    logic [DATA_W-1:0] w_byp;
    logic              r_hit;
    logic [DATA_W-1:0] r_byp;

    // Scan oldest to youngest so the last match wins; a same-cycle push is youngest of all
    always_comb begin
        w_hit = 1'b0;
        w_byp = '0;
        for (int k = 0; k < UQ_DEPTH; k++) begin
            if (CW'(k) < r_cnt && r_q_idx[r_rp + PW'(k)] == io_bus.lk_idx) begin
                w_hit = 1'b1;
                w_byp = r_q_data[r_rp + PW'(k)];
            end
        end
        if (w_push && io_bus.up_idx == io_bus.lk_idx) begin
            w_hit = 1'b1;
            w_byp = io_bus.up_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit <= 1'b0;
            r_byp <= '0;
        end else if (w_grant) begin
            r_hit <= w_hit;
            r_byp <= w_byp;
        end
    end

    assign w_rd = r_hit ? r_byp : io_bus.tbl_rdata;
`else
    assign w_rd = io_bus.tbl_rdata;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_wp]  <= io_bus.up_idx;
            r_q_data[r_wp] <= io_bus.up_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_INIT;
            r_sweep  <= '0;
            r_rp     <= '0;
            r_wp     <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
            r_rvalid <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_rvalid <= w_grant;
            if (r_rvalid)
                r_hold <= w_rd;
            if (io_bus.flush) begin
                r_state  <= S_INIT;
                r_sweep  <= '0;
                r_rp     <= '0;
                r_wp     <= '0;
                r_cnt    <= '0;
                r_starve <= '0;
            end else begin
                if (w_init) begin
                    r_sweep <= r_sweep + 1'b1;
                    if (&r_sweep)
                        r_state <= S_RUN;
                end
                if (w_wr)
                    r_rp <= r_rp + 1'b1;
                if (w_push)
                    r_wp <= r_wp + 1'b1;
                r_cnt    <= r_cnt + CW'(w_push) - CW'(w_wr);
                r_starve <= (w_wr || !w_ne) ? '0 :
                            (w_grant && r_starve != SW'(STARVE_MAX)) ? r_starve + 1'b1 : r_starve;
            end
        end
    end
endmodule

// File: tb/tb_bp_table_scheduler.sv
// tb_bp_table_scheduler: directed and random stimulus against a queue-based reference model
module tb_bp_table_scheduler;
    localparam int IDX_W = 7, DATA_W = 59, UQ_DEPTH = 4, STARVE_MAX = 3, N = 1 << IDX_W;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bp_table_scheduler_if #(.IDX_W(IDX_W), .DATA_W(DATA_W), .UQ_DEPTH(UQ_DEPTH)) bus ();
    bp_table_scheduler #(.IDX_W(IDX_W), .DATA_W(DATA_W), .UQ_DEPTH(UQ_DEPTH),
                         .STARVE_MAX(STARVE_MAX)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    logic [DATA_W-1:0] mem [N];
    logic              pre_en = 1'b0;
    logic [IDX_W-1:0]  pre_idx = '0;
    logic [DATA_W-1:0] pre_data = '0;

    // Single-ported synchronous-read table plus a backdoor preload port
    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_data;
        if (bus.tbl_en) begin
            if (bus.tbl_we)
                mem[bus.tbl_idx] <= bus.tbl_wdata;
            else
                bus.tbl_rdata <= mem[bus.tbl_idx];
        end
    end

    ent_t              q[$];
    logic [DATA_W-1:0] shadow [N];
    bit                m_run;
    int                m_sweep;
    int                m_starve;
    bit                e_rvalid;
    logic [DATA_W-1:0] e_rdata;
    bit                lk_pend;
    logic [IDX_W-1:0]  lk_pend_idx;
    int                n_tests = 0;
    int                n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.lk_valid = 1'b0;
        bus.lk_idx = '0;
        bus.up_valid = 1'b0;
        bus.up_idx = '0;
        bus.up_wdata = '0;
        #1;
        chk("rst_tbl_en", 64'(bus.tbl_en), 64'd0);
        chk("rst_tbl_we", 64'(bus.tbl_we), 64'd0);
        chk("rst_tbl_idx", 64'(bus.tbl_idx), 64'd0);
        chk("rst_tbl_wdata", 64'(bus.tbl_wdata), 64'd0);
        chk("rst_busy_init", 64'(bus.busy_init), 64'd1);
        chk("rst_uq_count", 64'(bus.uq_count), 64'd0);
        chk("rst_lk_rvalid", 64'(bus.lk_rvalid), 64'd0);
        chk("rst_lk_rdata", 64'(bus.lk_rdata), 64'd0);
        chk("rst_lk_ready", 64'(bus.lk_ready), 64'd0);
        q.delete();
        m_run = 1'b0;
        m_sweep = 0;
        m_starve = 0;
        e_rvalid = 1'b0;
        e_rdata = '0;
        lk_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive at the negedge, check #1 later, advance the model, wait for next negedge
    task automatic step(input bit fl, input bit lkv, input logic [IDX_W-1:0] lki,
                        input bit upv, input logic [IDX_W-1:0] upi, input logic [DATA_W-1:0] upd);
        bit full, ne, wr, gr, push;
        logic [IDX_W-1:0]  x_idx;
        logic [DATA_W-1:0] x_wd;
        bus.flush = fl;
        bus.lk_valid = lkv;
        bus.lk_idx = lki;
        bus.up_valid = upv;
        bus.up_idx = upi;
        bus.up_wdata = upd;
        #1;
        full = q.size() == UQ_DEPTH;
        ne = q.size() != 0;
        wr = m_run && ne && (full || m_starve == STARVE_MAX || !lkv);
        gr = m_run && lkv && !wr;
        push = m_run && !full && upv && !fl;
        x_idx = !m_run ? IDX_W'(m_sweep) : wr ? q[0].idx : gr ? lki : '0;
        x_wd = wr ? q[0].data : '0;
        chk("lk_ready", 64'(bus.lk_ready), 64'(gr));
        chk("up_ready", 64'(bus.up_ready), 64'(m_run && !full));
        chk("tbl_en", 64'(bus.tbl_en), 64'(!m_run || wr || gr));
        chk("tbl_we", 64'(bus.tbl_we), 64'(!m_run || wr));
        chk("tbl_idx", 64'(bus.tbl_idx), 64'(x_idx));
        chk("tbl_wdata", 64'(bus.tbl_wdata), 64'(x_wd));
        chk("busy_init", 64'(bus.busy_init), 64'(!m_run));
        chk("uq_count", 64'(bus.uq_count), 64'(q.size()));
        chk("lk_rvalid", 64'(bus.lk_rvalid), 64'(e_rvalid));
        chk("lk_rdata", 64'(bus.lk_rdata), 64'(e_rdata));
        e_rvalid = gr;
        if (gr) begin
            e_rdata = shadow[lki];
`ifdef BP_SCHED_BYPASS_EN
            foreach (q[i])
                if (q[i].idx == lki)
                    e_rdata = q[i].data;
            if (push && upi == lki)
                e_rdata = upd;
`endif
        end
        if (!m_run)
            shadow[m_sweep] = '0;
        if (wr) begin
            shadow[q[0].idx] = q[0].data;
            void'(q.pop_front());
        end
        m_starve = (wr || !ne) ? 0 : gr ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : m_starve;
        if (push)
            q.push_back(ent_t'{upi, upd});
        if (fl) begin
            m_run = 1'b0;
            m_sweep = 0;
            q.delete();
            m_starve = 0;
        end else if (!m_run) begin
            if (m_sweep == N - 1)
                m_run = 1'b1;
            m_sweep = (m_sweep + 1) % N;
        end
        lk_pend = lkv && !gr;
        lk_pend_idx = lki;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic preload(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d);
        pre_en = 1'b1;
        pre_idx = idx;
        pre_data = d;
        shadow[idx] = d;
        idle(1);
        pre_en = 1'b0;
    endtask

    initial begin
        logic [63:0] rnd;
        bit          lkv;
        logic [IDX_W-1:0] lki;
        @(negedge clk);
        do_reset();
        idle(N + 1);
        preload(7'h2A, 59'h1_2345_6789);
        step(1'b0, 1'b1, 7'h2A, 1'b0, '0, '0);
        chk("plan_2a_rvalid", 64'(bus.lk_rvalid), 64'd1);
        chk("plan_2a_rdata", 64'(bus.lk_rdata), 64'h1_2345_6789);
        idle(1);
        step(1'b0, 1'b1, 7'h03, 1'b1, 7'd5, 59'h0_5555_5555);
        repeat (6) step(1'b0, 1'b1, 7'h03, 1'b0, '0, '0);
        idle(3);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 7'h03, 1'b1, IDX_W'(20 + i), DATA_W'(64'h100 + 64'(i)));
        chk("plan_full_count", 64'(bus.uq_count), 64'd4);
        chk("plan_full_up_ready", 64'(bus.up_ready), 64'd0);
        repeat (3) step(1'b0, 1'b1, 7'h03, 1'b0, '0, '0);
        idle(6);
        step(1'b0, 1'b1, 7'h03, 1'b1, 7'd40, 59'h7_0000_0001);
        step(1'b0, 1'b1, 7'h03, 1'b1, 7'd41, 59'h7_0000_0002);
        step(1'b1, 1'b1, 7'h03, 1'b0, '0, '0);
        chk("plan_flush_count", 64'(bus.uq_count), 64'd0);
        chk("plan_flush_busy", 64'(bus.busy_init), 64'd1);
        idle(N + 1);
        step(1'b0, 1'b1, 7'd9, 1'b1, 7'd9, 59'h3_0000_0040);
        repeat (4) step(1'b0, 1'b1, 7'd9, 1'b0, '0, '0);
        idle(4);
        step(1'b0, 1'b1, 7'd4, 1'b1, 7'd6, 59'h2_0000_0006);
        do_reset();
        idle(N + 1);
        for (int c = 0; c < 2000; c++) begin
            lkv = lk_pend ? 1'b1 : 1'($urandom_range(0, 1));
            lki = lk_pend ? lk_pend_idx : IDX_W'($urandom_range(0, 15));
            rnd = {$urandom, $urandom};
            step($urandom_range(0, 99) == 0, lkv, lki, 1'($urandom_range(0, 1)),
                 IDX_W'($urandom_range(0, 15)), rnd[DATA_W-1:0]);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
